// File: rtl/masked_and_driver.sv
// rtl/masked_and_driver.sv - drives a 3-share masked AND gadget from unmasked operands
//
// Purpose: takes an unmasked operand pair, splits each operand into three
// Boolean shares using bits from an internal 32-bit LFSR, runs the external
// gadget for exactly three enabled cycles, then captures and presents the
// masked result shares.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake, a_in / b_in unmasked bits
//   seed_load / seed      reload the LFSR (a zero seed loads 1)
//   ina, inb, rin         operand shares and fresh randomness to the gadget
//   AndEnable / AndDone   gadget enable and completion flag
//   and_out               gadget output shares
//   out_valid / out_ready result handshake, out_shares masked result
//   sync_err              sticky: gadget completion was not seen on capture
module masked_and_driver #(
    parameter int          D    = 3,
    parameter logic [31:0] SEED = 32'hACE12468
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 seed_load,
    input  logic [31:0]          seed,
    output logic [0:D-1]         ina,
    output logic [0:D-1]         inb,
    output logic [0:D*(D-1)/2-1] rin,
    output logic                 AndEnable,
    input  logic                 AndDone,
    input  logic [0:D-1]         and_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:D-1]         out_shares,
    output logic                 sync_err
);

    typedef enum logic [1:0] {IDLE, ENA, CAPT, OUT} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] lfsr;
    logic [1:0]  cnt;
    logic        accept;
    logic        ena_done;
    logic        capture;
    logic        release_out;

    // Eight Fibonacci steps per clock so consecutive operations never reuse
    // overlapping mask bits.
    function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    assign in_ready = (state == IDLE);

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        ena_done    = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = ENA;
                end
            end
            ENA: begin
                if (cnt == 2'd2) begin
                    ena_done = 1'b1;
                    state_nx = CAPT;
                end
            end
            CAPT: begin
                capture  = 1'b1;
                state_nx = OUT;
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A reload wins over stepping regardless of FSM state; zero would lock
    // the LFSR, so it is replaced by 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (seed_load) begin
            lfsr <= (seed == 32'd0) ? 32'd1 : seed;
        end else begin
            lfsr <= lfsr_step8(lfsr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ina        <= '0;
            inb        <= '0;
            rin        <= '0;
            AndEnable  <= 1'b0;
            cnt        <= 2'd0;
            out_valid  <= 1'b0;
            out_shares <= '0;
            sync_err   <= 1'b0;
        end else begin
            if (accept) begin
                // Mask bits come from the LFSR value before this edge's step.
                ina       <= {a_in ^ lfsr[0] ^ lfsr[1], lfsr[0], lfsr[1]};
                inb       <= {b_in ^ lfsr[2] ^ lfsr[3], lfsr[2], lfsr[3]};
                rin       <= lfsr[6:4];
                AndEnable <= 1'b1;
                cnt       <= 2'd0;
            end
            if (state == ENA) begin
                cnt <= 2'(cnt + 2'd1);
            end
            if (ena_done) begin
                AndEnable <= 1'b0;
            end
            if (capture) begin
                out_shares <= and_out;
                out_valid  <= 1'b1;
                // Clear the gadget inputs so shares do not linger on the bus.
                ina        <= '0;
                inb        <= '0;
                rin        <= '0;
                if (!AndDone) begin
                    sync_err <= 1'b1;
                end
            end
            if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_masked_and_driver.sv
// tb/tb_masked_and_driver.sv - self-checking bench for masked_and_driver
module tb_masked_and_driver;

    localparam logic [31:0] SEED = 32'hACE12468;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        a_in;
    logic        b_in;
    logic        seed_load;
    logic [31:0] seed;
    logic [0:2]  ina;
    logic [0:2]  inb;
    logic [0:2]  rin;
    logic        AndEnable;
    logic        AndDone;
    logic [0:2]  and_out;
    logic        out_valid;
    logic        out_ready;
    logic [0:2]  out_shares;
    logic        sync_err;

    int n_checks = 0;
    int n_fail   = 0;

    masked_and_driver #(.D(3), .SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .seed_load  (seed_load),
        .seed       (seed),
        .ina        (ina),
        .inb        (inb),
        .rin        (rin),
        .AndEnable  (AndEnable),
        .AndDone    (AndDone),
        .and_out    (and_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: one step is a shift with the tap XOR fed back.
    function automatic logic [31:0] ref_step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 8; i++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    logic [31:0] mdl;
    logic [31:0] mdl_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl      <= SEED;
            mdl_prev <= SEED;
        end else begin
            mdl_prev <= mdl;
            if (seed_load) mdl <= (seed == 32'd0) ? 32'd1 : seed;
            else           mdl <= ref_step8(mdl);
        end
    end

    // Gadget model: completion counter starts at 0, counts enabled cycles,
    // flags done after three and clears once the enable drops.
    logic [2:0] gcnt;
    logic [0:2] g_out;
    logic       force_no_done;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt  <= 3'd0;
            g_out <= 3'b000;
        end else if (AndEnable) begin
            gcnt  <= gcnt + 3'd1;
            g_out <= {((^ina) & (^inb)) ^ rin[0] ^ rin[1], rin[0], rin[1]};
        end else if (gcnt == 3'd3) begin
            gcnt <= 3'd0;
        end
    end
    assign AndDone = (gcnt == 3'd3) && !force_no_done;
    assign and_out = g_out;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_seed(input logic [31:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // One full operation; out_ready must already be 1. Returns the mask
    // bits observed on the gadget bus.
    task automatic run_op(input logic a, input logic b, input logic exp_serr,
                          output logic [6:0] r_seen);
        logic [6:0] r;
        logic [0:2] ia0, ib0, rn0;
        int en_cnt, lat;
        logic unstable;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
        r        = mdl_prev[6:0];
        r_seen   = {rin[0], rin[1], rin[2], inb[2], inb[1], ina[2], ina[1]};
        check("in_ready_busy", in_ready, 0);
        check("ina_shares", ina, {a ^ r[0] ^ r[1], r[0], r[1]});
        check("inb_shares", inb, {b ^ r[2] ^ r[3], r[2], r[3]});
        check("rin_bits", rin, {r[6], r[5], r[4]});
        ia0 = ina; ib0 = inb; rn0 = rin;
        en_cnt = 0; lat = 0; unstable = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (AndEnable) begin
                en_cnt++;
                if (ina !== ia0 || inb !== ib0 || rin !== rn0) unstable = 1'b1;
            end
            if (out_valid) begin
                lat = k - 1;
                break;
            end
        end
        check("enable_cycles", en_cnt, 3);
        check("latency", lat, 4);
        check("shares_stable", unstable, 0);
        check("result_xor", ^out_shares, a & b);
        check("bus_cleared", {ina, inb, rin}, 0);
        check("sync_err", sync_err, exp_serr);
        @(negedge clk);
        check("back_idle", {in_ready, out_valid}, 2'b10);
    endtask

    typedef struct {
        logic        a;
        logic        b;
        logic [31:0] seed;
        logic        exp_and;
    } vec_t;

    vec_t vecs[16];
    logic [31:0] seeds[4];
    logic [6:0]  r_obs;
    logic [0:2]  held;
    logic [31:0] exp_lfsr;
    logic        ra, rb;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a_in = 1'b0; b_in = 1'b0;
        seed_load = 1'b0; seed = 32'd0; out_ready = 1'b1; force_no_done = 1'b0;

        seeds[0] = 32'h00000001; seeds[1] = 32'hDEADBEEF;
        seeds[2] = 32'h12345678; seeds[3] = 32'h80000000;
        for (int i = 0; i < 16; i++) begin
            vecs[i].a       = i[0];
            vecs[i].b       = i[1];
            vecs[i].seed    = seeds[i / 4];
            vecs[i].exp_and = i[0] & i[1];
        end

        // Reset state
        #12;
        check("reset_outputs", {ina, inb, rin, AndEnable, out_valid, out_shares, sync_err}, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic a=1, b=1 operation
        run_op(1'b1, 1'b1, 1'b0, r_obs);

        // Table sweep: four pairs under four seeds
        for (int i = 0; i < 16; i++) begin
            load_seed(vecs[i].seed);
            run_op(vecs[i].a, vecs[i].b, 1'b0, r_obs);
            check("table_xor", ^out_shares, vecs[i].exp_and);
        end

        // Zero seed loads 1; the accept two edges later sees 8 steps from 1
        load_seed(32'd0);
        exp_lfsr = ref_step8(32'h00000001);
        run_op(1'b1, 1'b0, 1'b0, r_obs);
        check("seed_zero_mask", r_obs, exp_lfsr[6:0]);

        // Randomized operations with occasional reseeding
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) load_seed($urandom);
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            run_op(ra, rb, 1'b0, r_obs);
        end

        // Consumer back-pressure for 10 cycles
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a_in = 1'b1; b_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check("hold_valid_seen", out_valid, 1);
        held = out_shares;
        begin
            logic bad;
            bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
                in_valid = k[0];
                a_in     = 1'b0;
                @(negedge clk);
                if (out_valid !== 1'b1 || out_shares !== held || in_ready !== 1'b0) bad = 1'b1;
            end
            check("hold_stable", bad, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("hold_xor", ^held, 1);
        @(negedge clk);
        check("release_idle", {in_ready, out_valid}, 2'b10);
        check("shares_kept", out_shares, held);

        // Gadget never completes: sticky sync_err
        force_no_done = 1'b1;
        run_op(1'b0, 1'b1, 1'b1, r_obs);
        force_no_done = 1'b0;
        run_op(1'b1, 1'b1, 1'b1, r_obs);

        // Reset during ENA, then a clean operation
        @(negedge clk);
        in_valid = 1'b1; a_in = 1'b1; b_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {ina, inb, rin, AndEnable, out_valid, out_shares, sync_err}, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 1'b1, 1'b0, r_obs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
